// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - RV32I fetch stage: PC, IMEM req/ack, issue qualifier, instret, fault (option: MISALIGN_TRAP_EN)
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] aluResult,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        inst_valid,
    output logic [31:0] instret,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  timeout_cnt;
    logic [31:0] target;
    logic        misaligned;

    assign pcPlus4   = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH) && !rst;

    // Without the trap the low target bits are simply dropped to keep PC word aligned.
    assign target     = TRAP_EN ? aluResult : {aluResult[31:2], 2'b00};
    assign misaligned = TRAP_EN && PCSel && (aluResult[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst        <= NOP;
            inst_valid  <= 1'b0;
            instret     <= 32'd0;
            fetch_fault <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        inst        <= imem_rdata;
                        inst_valid  <= 1'b1;
                        timeout_cnt <= 8'd0;
                        state       <= ISSUE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_cnt <= 8'd0;
                        fetch_fault <= 1'b1;
                        state       <= FAULT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        inst       <= NOP;
                        inst_valid <= 1'b0;
                        if (misaligned) begin
                            fetch_fault <= 1'b1;
                            state       <= FAULT;
                        end else begin
                            pc      <= PCSel ? target : pcPlus4;
                            instret <= instret + 32'd1;
                            state   <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    inst        <= NOP;
                    inst_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    inst        <= NOP;
                    inst_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                    state       <= FAULT;
                end
            endcase
        end
    end

endmodule
